// File: rtl/traffic_pkg.sv
// Shared types for the traffic sensor front end: light colour encoding,
// per-channel request state and the number of detector channels.
package traffic_pkg;

  typedef enum logic [1:0] {
    red    = 2'd0,
    yellow = 2'd1,
    green  = 2'd2
  } color;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    SERVING
  } chan_state_e;

  localparam int SENSOR_CNT = 3;

endpackage

// File: rtl/traffic_sensor_channel.sv
// One detector channel: 2-flop synchroniser, debounce, request-latch FSM
// driven by the controller's light feedback, and a saturating wait counter.
module traffic_sensor_channel
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = 3,
  parameter int WAIT_W     = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       raw_i,
  input  logic [1:0] light_i,
  output logic       sensor_o,
  output logic       starve_o
);

  localparam logic [3:0]        DEB_LAST = 4'(DEB_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  logic [1:0]        sync_q;
  logic [3:0]        deb_cnt_q, deb_cnt_d;
  logic              deb_q, deb_d;
  chan_state_e       state_q;
  logic [WAIT_W-1:0] wait_q;
  logic              sensor_q;
  logic              starve_q;
  logic              is_green;

  // Encoding 3 is not a named colour, so it never compares equal to green.
  assign is_green = (color'(light_i) == green);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = ~deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // A light change wins over a debounce change in the same cycle: the exit
  // decision from SERVING uses the level already established.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      sensor_q <= 1'b0;
      starve_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wait_q   <= '0;
          starve_q <= 1'b0;
          if (deb_q) begin
            state_q  <= PENDING;
            sensor_q <= 1'b1;
          end else begin
            sensor_q <= 1'b0;
          end
        end
        PENDING: begin
          if (is_green) begin
            state_q  <= SERVING;
            sensor_q <= deb_q;
            wait_q   <= '0;
            starve_q <= 1'b0;
          end else begin
            sensor_q <= 1'b1;
            if (wait_q != WAIT_MAX) begin
              wait_q <= wait_q + WAIT_W'(1);
            end
            starve_q <= (wait_q >= WAIT_MAX - WAIT_W'(1));
          end
        end
        SERVING: begin
          sensor_q <= deb_q;
          wait_q   <= '0;
          starve_q <= 1'b0;
          if (!is_green) begin
            state_q <= deb_q ? PENDING : IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          wait_q   <= '0;
          sensor_q <= 1'b0;
          starve_q <= 1'b0;
        end
      endcase
    end
  end

  assign sensor_o = sensor_q;
  assign starve_o = starve_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Front end for traffic_light_controller: three independent detector
// channels, each paired with the light that serves that direction.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = 3,
  parameter int WAIT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ew_left_raw,
  input  logic       ew_str_raw,
  input  logic       ns_raw,
  input  logic [1:0] ew_left_light,
  input  logic [1:0] ew_str_light,
  input  logic [1:0] ns_light,
  output logic       ew_left_sensor,
  output logic       ew_str_sensor,
  output logic       ns_sensor,
  output logic       ew_left_starve,
  output logic       ew_str_starve,
  output logic       ns_starve
);

  logic [SENSOR_CNT-1:0] raw_w;
  logic [SENSOR_CNT-1:0] sensor_w;
  logic [SENSOR_CNT-1:0] starve_w;
  logic [1:0]            light_w [SENSOR_CNT];

  // Channel order: 0 e-w left, 1 e-w straight, 2 n-s.
  assign raw_w      = {ns_raw, ew_str_raw, ew_left_raw};
  assign light_w[0] = ew_left_light;
  assign light_w[1] = ew_str_light;
  assign light_w[2] = ns_light;

  for (genvar g = 0; g < SENSOR_CNT; g++) begin : g_chan
    traffic_sensor_channel #(
      .DEB_CYCLES(DEB_CYCLES),
      .WAIT_W    (WAIT_W)
    ) u_chan (
      .clk_i   (clk),
      .rst_ni  (reset),
      .raw_i   (raw_w[g]),
      .light_i (light_w[g]),
      .sensor_o(sensor_w[g]),
      .starve_o(starve_w[g])
    );
  end

  assign ew_left_sensor = sensor_w[0];
  assign ew_str_sensor  = sensor_w[1];
  assign ns_sensor      = sensor_w[2];
  assign ew_left_starve = starve_w[0];
  assign ew_str_starve  = starve_w[1];
  assign ns_starve      = starve_w[2];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed plus randomized bench for traffic_sensor_conditioner, checked
// against a per-channel behavioural model of request latching and service.
module tb_traffic_sensor_conditioner;

  localparam int DEB      = 3;
  localparam int WAIT_W   = 4;
  localparam int WAIT_MAX = (1 << WAIT_W) - 1;
  localparam logic [1:0] RED = 2'd0, YEL = 2'd1, GRN = 2'd2, BAD = 2'd3;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] rawVec = '0;
  logic [1:0] lightVec [3];
  logic [2:0] sensorVec;
  logic [2:0] starveVec;

  int testCount = 0;
  int failCount = 0;

  // Model: delayed raw samples, debounced level, request bookkeeping.
  logic [1:0] rawDelay [3];
  logic       debLevel [3];
  int         disagreeRun [3];
  bit         waiting [3];
  bit         serving [3];
  int         waited [3];
  logic       expSensor [3];
  logic       expStarve [3];

  traffic_sensor_conditioner #(
    .DEB_CYCLES(DEB),
    .WAIT_W    (WAIT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ew_left_raw   (rawVec[0]),
    .ew_str_raw    (rawVec[1]),
    .ns_raw        (rawVec[2]),
    .ew_left_light (lightVec[0]),
    .ew_str_light  (lightVec[1]),
    .ns_light      (lightVec[2]),
    .ew_left_sensor(sensorVec[0]),
    .ew_str_sensor (sensorVec[1]),
    .ns_sensor     (sensorVec[2]),
    .ew_left_starve(starveVec[0]),
    .ew_str_starve (starveVec[1]),
    .ns_starve     (starveVec[2])
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    for (int c = 0; c < 3; c++) begin
      rawDelay[c] = '0; debLevel[c] = 1'b0; disagreeRun[c] = 0;
      waiting[c] = 1'b0; serving[c] = 1'b0; waited[c] = 0;
      expSensor[c] = 1'b0; expStarve[c] = 1'b0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelStep();
    logic debSeen, sample, isGreen;
    if (!reset) begin
      modelReset();
      return;
    end
    for (int c = 0; c < 3; c++) begin
      debSeen = debLevel[c];
      sample  = rawDelay[c][1];
      rawDelay[c] = {rawDelay[c][0], rawVec[c]};
      if (sample != debLevel[c]) begin
        disagreeRun[c]++;
        if (disagreeRun[c] == DEB) begin
          debLevel[c]    = ~debLevel[c];
          disagreeRun[c] = 0;
        end
      end else begin
        disagreeRun[c] = 0;
      end
      isGreen = (lightVec[c] == GRN);
      if (serving[c]) begin
        expSensor[c] = debSeen;
        if (!isGreen) begin
          serving[c] = 1'b0;
          waiting[c] = debSeen;
        end
        waited[c] = 0;
      end else if (waiting[c]) begin
        if (isGreen) begin
          waiting[c] = 1'b0; serving[c] = 1'b1; waited[c] = 0;
          expSensor[c] = debSeen;
        end else begin
          waited[c] = (waited[c] < WAIT_MAX) ? waited[c] + 1 : WAIT_MAX;
          expSensor[c] = 1'b1;
        end
      end else begin
        waiting[c]   = debSeen;
        expSensor[c] = debSeen;
        waited[c]    = 0;
      end
      expStarve[c] = (waited[c] == WAIT_MAX);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    for (int c = 0; c < 3; c++) begin
      checkValue($sformatf("%s sensor[%0d]", tag, c), 32'(sensorVec[c]), 32'(expSensor[c]));
      checkValue($sformatf("%s starve[%0d]", tag, c), 32'(starveVec[c]), 32'(expStarve[c]));
    end
  endtask

  task automatic applyStimulus(input logic [2:0] raws, input logic [1:0] l0,
                               input logic [1:0] l1, input logic [1:0] l2);
    rawVec      = raws;
    lightVec[0] = l0;
    lightVec[1] = l1;
    lightVec[2] = l2;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("step");
  endtask

  task automatic asyncResetPulse(input string tag);
    #2 reset = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    checkValue({tag, " allOutputs"}, 32'({sensorVec, starveVec}), 32'd0);
    #1 reset = 1'b1;
  endtask

  initial begin
    int firstRise, starveRise;
    logic [2:0] riseVec;
    logic glitchSeen;
    int holdRaw, holdLight;

    lightVec[0] = RED; lightVec[1] = RED; lightVec[2] = RED;
    modelReset();

    // Reset held with all raws high: nothing may leak through.
    #1 reset = 1'b0;
    #1 checkOutput("resetAsync");
    applyStimulus(3'b111, RED, RED, RED);
    applyStimulus(3'b111, RED, RED, RED);
    checkValue("resetHeldOutputs", 32'({sensorVec, starveVec}), 32'd0);
    reset = 1'b1;

    firstRise = -1;
    riseVec   = '0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'b111, RED, RED, RED);
      if (firstRise < 0 && sensorVec != 3'b000) begin
        firstRise = i;
        riseVec   = sensorVec;
      end
    end
    checkValue("releaseRiseEdge", 32'(firstRise), 32'(DEB + 2));
    checkValue("allRiseTogether", 32'(riseVec), 32'b111);

    for (int i = 0; i < 8; i++) applyStimulus(3'b000, RED, RED, RED);
    checkValue("latchedAfterFall", 32'(sensorVec), 32'b111);
    asyncResetPulse("midReset");

    // Glitch of DEB-1 clocks on n-s must be rejected.
    glitchSeen = 1'b0;
    applyStimulus(3'b100, RED, RED, RED);
    applyStimulus(3'b100, RED, RED, RED);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(3'b000, RED, RED, RED);
      glitchSeen |= sensorVec[2];
    end
    checkValue("glitchRejected", 32'(glitchSeen), 32'd0);

    // Clean 3-clock pulse latches, then starves with red held.
    firstRise  = -1;
    starveRise = -1;
    for (int i = 0; i < 30; i++) begin
      applyStimulus((i < 3) ? 3'b100 : 3'b000, RED, RED, RED);
      if (firstRise < 0 && sensorVec[2]) firstRise = i;
      if (starveRise < 0 && starveVec[2]) starveRise = i;
    end
    checkValue("nsRiseEdge", 32'(firstRise), 32'(DEB + 2));
    checkValue("nsStarveEdge", 32'(starveRise), 32'(DEB + 2 + WAIT_MAX));
    checkValue("nsLatched", 32'(sensorVec[2]), 32'd1);
    checkValue("nsStarveHeld", 32'(starveVec[2]), 32'd1);
    applyStimulus(3'b000, RED, RED, GRN);
    checkValue("starveClearOnGreen", 32'(starveVec[2]), 32'd0);
    applyStimulus(3'b000, RED, RED, BAD);
    applyStimulus(3'b000, RED, RED, RED);
    checkValue("nsIdleAfterServe", 32'(sensorVec[2]), 32'd0);

    // Serve cycle on e-w left: sensor follows the (low) debounced level.
    for (int i = 0; i < 12; i++) applyStimulus((i < 4) ? 3'b001 : 3'b000, RED, RED, RED);
    checkValue("ewLeftLatched", 32'(sensorVec[0]), 32'd1);
    applyStimulus(3'b000, GRN, RED, RED);
    checkValue("ewLeftServingLow", 32'(sensorVec[0]), 32'd0);
    applyStimulus(3'b000, YEL, RED, RED);
    applyStimulus(3'b000, RED, RED, RED);
    checkValue("ewLeftIdle", 32'(sensorVec[0]), 32'd0);

    // Re-request: e-w straight stays high through green, re-latches on yellow.
    for (int i = 0; i < 8; i++) applyStimulus(3'b010, RED, RED, RED);
    for (int i = 0; i < 4; i++) applyStimulus(3'b010, RED, GRN, RED);
    checkValue("ewStrServingHigh", 32'(sensorVec[1]), 32'd1);
    applyStimulus(3'b010, RED, YEL, RED);
    checkValue("ewStrRelatched", 32'(sensorVec[1]), 32'd1);
    starveRise = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(3'b010, RED, RED, RED);
      if (starveRise < 0 && starveVec[1]) starveRise = i;
    end
    checkValue("ewStrWaitRestart", 32'(starveRise), 32'(WAIT_MAX - 1));
    for (int i = 0; i < 6; i++) applyStimulus(3'b000, RED, GRN, RED);

    // Randomized traffic with held inputs and occasional illegal light value.
    holdRaw   = 0;
    holdLight = 0;
    for (int n = 0; n < 500; n++) begin
      if (holdRaw == 0) begin
        rawVec  = 3'($urandom_range(0, 7));
        holdRaw = $urandom_range(1, 7);
      end
      if (holdLight == 0) begin
        for (int c = 0; c < 3; c++) lightVec[c] = 2'($urandom_range(0, 3));
        holdLight = $urandom_range(1, 20);
      end
      holdRaw--;
      holdLight--;
      applyStimulus(rawVec, lightVec[0], lightVec[1], lightVec[2]);
      if (n == 250) asyncResetPulse("randomReset");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/traffic_sensor_conditioner.md
Name: traffic_sensor_conditioner

Overview:
Upstream front end for traffic_light_controller. Takes three raw, noisy, asynchronous vehicle-loop detector inputs (e-w left, e-w straight, n-s). For each one it synchronises, debounces and latches a service request. It drives the controller's ew_left_sensor / ew_str_sensor / ns_sensor inputs and watches the controller's light outputs to know when a request has been served. It also flags any direction that waits too long without service.

Parameters:
DEB_CYCLES, 3, consecutive synchronised samples needed to change a debounced level (range 1..15)
WAIT_W, 8, width of the per-channel wait counter; starve asserts at 2^WAIT_W-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
ew_left_raw  input  1  raw loop detector, e-w left; asynchronous to clk
ew_str_raw  input  1  raw loop detector, e-w straight; asynchronous
ns_raw  input  1  raw loop detector, n-s; asynchronous
ew_left_light  input  2  controller feedback: 0 red, 1 yellow, 2 green, 3 treated as red
ew_str_light  input  2  controller feedback, same encoding
ns_light  input  2  controller feedback, same encoding
ew_left_sensor  output  1  conditioned request to controller
ew_str_sensor  output  1  conditioned request to controller
ns_sensor  output  1  conditioned request to controller
ew_left_starve  output  1  wait counter saturated, e-w left
ew_str_starve  output  1  wait counter saturated, e-w straight
ns_starve  output  1  wait counter saturated, n-s

Behaviour:
- Three identical, independent channels. Each channel pairs one raw input with its own light input.
- Reset (reset=0, asynchronous): sync flops 0, debounce counter 0, debounced level 0, FSM IDLE, wait counter 0. Every sensor and starve output is 0 while reset is low and on the first edge after release.
- Synchroniser: 2-flop chain on each raw input.
- Debounce: a counter counts consecutive synchronised samples that differ from the current debounced level. When the count reaches DEB_CYCLES, the debounced level flips and the counter clears. Any sample equal to the current level clears the counter. A glitch shorter than DEB_CYCLES clocks never reaches the output.
- Latency: a clean raw rise sampled at edge k gives sensor=1 at edge k+DEB_CYCLES+2. Falls take the same time.
- Per-channel FSM; all outputs are registered:
  - IDLE: sensor=0. Debounced=1 moves to PENDING.
  - PENDING: sensor=1, held even if the debounced level falls, because the car is latched. Light==green moves to SERVING.
  - SERVING: sensor follows the debounced level live, so the controller can extend or end green. When light leaves green (yellow, red or 3), go to PENDING if debounced=1, else IDLE.
- Simultaneous events: the light==green check takes priority over the debounced change in the same cycle. Entering PENDING with light already green goes to SERVING on the next edge.
- Wait counter:
  - Increments each clock while in PENDING and saturates at 2^WAIT_W-1 (no wrap).
  - starve=1 while saturated.
  - Clears to 0 on any transition out of PENDING.
- Illegal light value 3 is treated as red: it never starts SERVING, and it ends SERVING.
- Reset mid-operation aborts all state immediately. Nothing is retained.

Decomposition:
- Shared package traffic_pkg:
  - typedef enum logic[1:0] {red, yellow, green} color
  - channel state enum {IDLE, PENDING, SERVING}
  - SENSOR_CNT=3 constant
- One sub-module, traffic_sensor_channel: sync, debounce, FSM and wait counter for a single direction. The top instantiates it three times and does only port wiring.

Test Plan (DEB_CYCLES=3, WAIT_W=4, lights driven by the bench):
- Reset/quiescent: hold reset=0 for 2 clocks with all raws=1. All six outputs stay 0. Release reset: first sensor rises exactly 5 clocks after release.
- Glitch rejection: ns_raw high for 2 clocks, then low. ns_sensor stays 0 for 20 clocks. Then ns_raw high for 3 clocks: ns_sensor=1 at edge +5 and stays 1 after the raw falls (latched PENDING).
- Serve cycle:
  - ew_left_raw pulse of 4 clocks → ew_left_sensor=1.
  - Drive ew_left_light=green → next edge SERVING; sensor follows debounced (0).
  - Light goes yellow → IDLE; sensor stays 0.
- Re-request on exit: ew_str_raw held high through green. On light=yellow, ew_str_sensor stays 1 (PENDING) and the wait counter restarts from 0.
- Starvation: ns latched, light held red. ns_starve=1 exactly 15 clocks after entering PENDING and stays 1. Light=green clears starve on the next edge.
- All three raws rise together: all three sensors assert on the same edge (+5). A mid-test reset=0 pulse clears every output asynchronously, before the next clk edge.
